// File: rtl/conv_layer_pkg.sv
// Shared helpers for the convolution stage: accumulator sizing and the
// output ReLU/saturation stage.
package cnn_pkg;

  localparam int MaxWidth = 64;

  function automatic int acc_width(input int bit_size, input int k);
    return 2 * bit_size + $clog2(k * k) + 1;
  endfunction

  // Rescale out of the fixed-point product format, then clamp to [0, 2^(bit_size-1)-1].
  function automatic logic [MaxWidth-1:0] sat_relu(input logic signed [MaxWidth-1:0] acc,
                                                  input int frac_bits,
                                                  input int bit_size);
    logic signed [MaxWidth-1:0] shifted;
    logic signed [MaxWidth-1:0] max_val;
    shifted = acc >>> frac_bits;
    max_val = (64'sd1 <<< (bit_size - 1)) - 64'sd1;
    if (shifted < 64'sd0) begin
      sat_relu = '0;
    end else if (shifted > max_val) begin
      sat_relu = max_val;
    end else begin
      sat_relu = shifted;
    end
  endfunction

endpackage

// File: rtl/conv_layer_mac.sv
// KxK multiply-accumulate with bias; one register stage holding the sum.
module conv_mac
  import cnn_pkg::*;
#(
  parameter int K        = 3,
  parameter int BitSize  = 16,
  parameter int FracBits = 0,
  parameter int AccWidth = acc_width(BitSize, K)
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         in_valid,
  input  logic [K*K*BitSize-1:0]       in_window,
  input  logic [K*K*BitSize-1:0]       in_weights,
  input  logic [BitSize-1:0]           in_bias,
  output logic                         out_valid,
  output logic signed [AccWidth-1:0]   out_acc
);

  localparam int ProdWidth = 2 * BitSize;

  logic signed [ProdWidth-1:0] prod;
  logic signed [AccWidth-1:0]  sum;

  always_comb begin
    prod = '0;
    sum  = AccWidth'($signed(in_bias)) <<< FracBits;
    for (int i = 0; i < K * K; i++) begin
      prod = ProdWidth'($signed(in_window[i*BitSize +: BitSize]))
           * ProdWidth'($signed(in_weights[i*BitSize +: BitSize]));
      sum  = sum + AccWidth'(prod);
    end
  end

  // The sum is only reloaded for real windows so the output holds between results.
  always_ff @(posedge clk) begin
    if (res) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_acc <= sum;
      end
    end
  end

endmodule

// File: rtl/conv_layer.sv
// Streaming single-channel KxK valid convolution with ReLU and saturation,
// two-cycle latency, no backpressure.
module conv_layer
  import cnn_pkg::*;
#(
  parameter int K           = 3,
  parameter int ImageWidth  = 6,
  parameter int ImageHeight = 6,
  parameter int BitSize     = 16,
  parameter int FracBits    = 0
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   in_valid,
  input  logic [BitSize-1:0]     in_data,
  input  logic [K*K*BitSize-1:0] in_weights,
  input  logic [BitSize-1:0]     in_bias,
  output logic                   out_ready,
  output logic                   out_valid,
  output logic [BitSize-1:0]     out_data,
  output logic                   out_done
);

  localparam int BufLen   = (K - 1) * ImageWidth + K;
  localparam int AccWidth = acc_width(BitSize, K);
  localparam int ColW     = $clog2(ImageWidth);
  localparam int RowW     = $clog2(ImageHeight);

  logic [BitSize-1:0]         line_buf [BufLen];
  logic [BitSize-1:0]         shifted  [BufLen];
  logic [K*K*BitSize-1:0]     window_next;
  logic [K*K*BitSize-1:0]     window;
  logic [ColW-1:0]            col;
  logic [RowW-1:0]            row;
  logic                       complete;
  logic                       last_px;
  logic                       win_valid;
  logic                       win_last;
  logic                       done_q;
  logic                       mac_valid;
  logic signed [AccWidth-1:0] mac_acc;

  // Buffer contents as they will be after accepting in_data; the window taps read this view.
  always_comb begin
    shifted[0] = in_data;
    for (int i = 1; i < BufLen; i++) begin
      shifted[i] = line_buf[i-1];
    end
  end

  always_comb begin
    window_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_next[(r*K+c)*BitSize +: BitSize] = shifted[(K-1-r)*ImageWidth + (K-1-c)];
      end
    end
  end

  assign complete = (col >= ColW'(K - 1)) && (row >= RowW'(K - 1));
  assign last_px  = (col == ColW'(ImageWidth - 1)) && (row == RowW'(ImageHeight - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      col       <= '0;
      row       <= '0;
      window    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int i = 0; i < BufLen; i++) begin
        line_buf[i] <= '0;
      end
    end else begin
      win_valid <= in_valid && complete;
      win_last  <= in_valid && last_px;
      if (in_valid) begin
        for (int i = 0; i < BufLen; i++) begin
          line_buf[i] <= shifted[i];
        end
        window <= window_next;
        if (col == ColW'(ImageWidth - 1)) begin
          col <= '0;
          row <= (row == RowW'(ImageHeight - 1)) ? '0 : row + RowW'(1);
        end else begin
          col <= col + ColW'(1);
        end
      end
    end
  end

  conv_mac #(
    .K        (K),
    .BitSize  (BitSize),
    .FracBits (FracBits),
    .AccWidth (AccWidth)
  ) u_mac (
    .clk        (clk),
    .res        (res),
    .in_valid   (win_valid),
    .in_window  (window),
    .in_weights (in_weights),
    .in_bias    (in_bias),
    .out_valid  (mac_valid),
    .out_acc    (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      done_q <= 1'b0;
    end else begin
      done_q <= win_last;
    end
  end

  assign out_ready = 1'b1;
  assign out_valid = mac_valid;
  assign out_done  = done_q;
  assign out_data  = BitSize'(sat_relu(MaxWidth'(mac_acc), FracBits, BitSize));

endmodule

// File: tb/tb_conv_layer.sv
// Scoreboard bench for conv_layer: a 16-bit integer instance and an 8-bit Q4 instance,
// each checked against an image-level convolution model.
module tb_conv_layer;

  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int OW = W - K + 1;
  localparam int OH = H - K + 1;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic                va, ova, oda, ora;
  logic [15:0]         da, ba, oa;
  logic [K*K*16-1:0]   wa;
  logic                vb, ovb, odb, orb;
  logic [7:0]          db, bb, ob;
  logic [K*K*8-1:0]    wb;

  conv_layer #(.K(K), .ImageWidth(W), .ImageHeight(H), .BitSize(16), .FracBits(0)) dut_a (
    .clk(clk), .res(res), .in_valid(va), .in_data(da), .in_weights(wa), .in_bias(ba),
    .out_ready(ora), .out_valid(ova), .out_data(oa), .out_done(oda));

  conv_layer #(.K(K), .ImageWidth(W), .ImageHeight(H), .BitSize(8), .FracBits(4)) dut_b (
    .clk(clk), .res(res), .in_valid(vb), .in_data(db), .in_weights(wb), .in_bias(bb),
    .out_ready(orb), .out_valid(ovb), .out_data(ob), .out_done(odb));

  typedef struct {
    longint val;
    bit     done;
    longint due;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  int     compared   = 0;
  int     mismatched = 0;
  longint cnt        = 0;

  longint img [H][W];
  longint wt  [K*K];
  longint bias;
  longint exp_img [OH][OW];

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input longint act, input longint req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cnt);
    end
  endtask

  // Plain convolution of the current image: correlate, add scaled bias, rescale, clamp.
  task automatic model(input int bits, input int frac);
    longint acc, v, mx;
    mx = (longint'(1) << (bits - 1)) - 1;
    for (int i = 0; i < OH; i++) begin
      for (int j = 0; j < OW; j++) begin
        acc = bias * (longint'(1) << frac);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            acc += img[i+r][j+c] * wt[r*K+c];
        v = acc >>> frac;
        if (v < 0) v = 0;
        if (v > mx) v = mx;
        exp_img[i][j] = v;
      end
    end
  endtask

  task automatic load(input int sel);
    for (int i = 0; i < K * K; i++) begin
      if (sel == 0) wa[i*16 +: 16] = 16'(wt[i]);
      else          wb[i*8 +: 8]   = 8'(wt[i]);
    end
    if (sel == 0) ba = 16'(bias);
    else          bb = 8'(bias);
  endtask

  task automatic mon(input int sel, input logic v, input longint d, input logic dn);
    exp_t e;
    string tag;
    tag = (sel == 0) ? "a" : "b";
    if (!v && dn) chk({"done_idle_", tag}, dn, 0);
    if (v) begin
      if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
        chk({"unexpected_valid_", tag}, v, 0);
      end else begin
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        chk({"data_", tag}, d, e.val);
        chk({"done_", tag}, dn, e.done);
        chk({"latency_", tag}, cnt, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ova, longint'($signed(oa)), oda);
    mon(1, ovb, longint'($signed(ob)), odb);
  end

  // Streams one image; expectations enter the scoreboard as completing pixels are driven.
  task automatic send_image(input int sel, input int max_gap, input int abort_at);
    exp_t e;
    int r, c;
    for (int p = 0; p < W * H; p++) begin
      r = p / W;
      c = p % W;
      if (sel == 0) begin va = 1'b1; da = 16'(img[r][c]); end
      else          begin vb = 1'b1; db = 8'(img[r][c]);  end
      if (r >= K - 1 && c >= K - 1) begin
        e.val  = exp_img[r-K+1][c-K+1];
        e.done = (r == H - 1 && c == W - 1);
        e.due  = cnt + 2;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
      end
      @(posedge clk); #1;
      va = 1'b0;
      vb = 1'b0;
      if (p == abort_at) begin
        res = 1'b1;
        va  = 1'b1;
        vb  = 1'b1;
        q_a.delete();
        q_b.delete();
        @(posedge clk); #1;
        res = 1'b0;
        va  = 1'b0;
        vb  = 1'b0;
        chk("valid_after_reset", ova || ovb, 0);
        chk("data_after_reset_a", oa, 0);
        return;
      end
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic fill_img(input longint base, input longint step);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = base + step * (r * W + c);
  endtask

  task automatic fill_wt(input longint v);
    for (int i = 0; i < K * K; i++) wt[i] = v;
  endtask

  task automatic rand_img(input int lo, input int span);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = longint'(lo) + longint'($urandom_range(span, 0));
  endtask

  initial begin
    res = 1'b1;
    va = 1'b0; vb = 1'b0; da = '0; db = '0;
    wa = '0; wb = '0; ba = '0; bb = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_valid_a", ova, 0);
    chk("reset_done_a", oda, 0);
    chk("reset_data_a", oa, 0);
    chk("ready_a", ora, 1);
    chk("reset_valid_b", ovb, 0);
    chk("reset_data_b", ob, 0);
    chk("ready_b", orb, 1);
    res = 1'b0;

    // Unit weights over a ramp, continuous then with idle gaps.
    fill_wt(1); bias = 0; load(0);
    fill_img(0, 1); model(16, 0);
    send_image(0, 0, -1); drain();
    send_image(0, 3, -1); drain();

    // Negative weights: everything clipped by ReLU.
    fill_wt(-1); load(0); model(16, 0);
    send_image(0, 0, -1); drain();

    // Reset after pixel 10, then a fresh image; then two images back-to-back.
    fill_wt(1); load(0); model(16, 0);
    send_image(0, 0, 10);
    send_image(0, 0, -1); drain();
    send_image(0, 0, -1);
    send_image(0, 0, -1); drain();

    // Random images sharing one weight set, streamed without reset.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < K * K; i++) wt[i] = longint'($urandom_range(100, 0)) - 50;
      bias = longint'($urandom_range(2000, 0)) - 1000;
      load(0);
      for (int n = 0; n < 3; n++) begin
        rand_img(-200, 400); model(16, 0);
        send_image(0, 2, -1);
      end
      drain();
    end

    // Q4 8-bit instance: saturation, centre tap with fractional bias, negative bias.
    fill_wt(16); bias = 0; load(1);
    fill_img(127, 0); model(8, 4);
    send_image(1, 1, -1); drain();
    fill_wt(0); wt[4] = 16; bias = 8; load(1);
    fill_img(32, 0); model(8, 4);
    send_image(1, 0, -1); drain();
    fill_wt(16); bias = -128; load(1);
    fill_img(0, 0); model(8, 4);
    send_image(1, 0, -1); drain();

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < K * K; i++) wt[i] = longint'($urandom_range(63, 0)) - 32;
      bias = longint'($urandom_range(255, 0)) - 128;
      load(1);
      for (int n = 0; n < 2; n++) begin
        rand_img(-128, 255); model(8, 4);
        send_image(1, 3, -1);
      end
      drain();
    end

    drain();
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
